// File: rtl/riscv_pkg.sv
// Core-wide constants and small shared types for the RISC-V pipeline.
// Also holds the requester count and ID type for the shared adder.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam int N_ADD_REQ = 4;

   typedef logic [$clog2(N_ADD_REQ)-1:0] add_req_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: scans requests starting at ptr and wrapping modulo N.
// Produces a one-hot grant, the matching index and a found flag.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 found
);

   localparam int IW = $clog2(N);

   logic [IW-1:0] cand;

   // The outer loop walks the rotated priority order.
   // The inner loop matches the candidate position, which avoids a variable bit-select.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         cand = IW'((int'(ptr) + k) % N);
         for (int i = 0; i < N; i++) begin
            if (!found && (cand == IW'(i)) && req[i]) begin
               found    = 1'b1;
               grant[i] = 1'b1;
               idx      = IW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/sum.sv
// Plain XLEN-wide adder shared by several datapath units.
// Any carry out of the top bit is discarded.
module sum #(
   parameter int W = 32
) (
   input  logic [W-1:0] A0,
   input  logic [W-1:0] A1,
   output logic [W-1:0] F
);

   assign F = A0 + A1;

endmodule

// File: rtl/adder_arbiter.sv
// Shares one XLEN-bit adder among N_REQ requesters with round-robin grant.
// The result is registered and returned as a single tagged valid/ready response.
module adder_arbiter
   import riscv_pkg::*;
#(
   parameter int N_REQ = N_ADD_REQ
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*XLEN-1:0]      req_a,
   input  logic [N_REQ*XLEN-1:0]      req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [XLEN-1:0]            rsp_data,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [31:0]                op_count
);

   localparam int IW = $clog2(N_REQ);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   logic [0:0]       state;
   logic [IW-1:0]    rr_ptr;
   logic [IW-1:0]    gidx;
   logic [IW-1:0]    next_ptr;
   logic [N_REQ-1:0] grant;
   logic             gfound;
   logic             can_issue;
   logic             issue;
   logic [XLEN-1:0]  a_sel;
   logic [XLEN-1:0]  b_sel;
   logic [XLEN-1:0]  sum_f;

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (gidx),
      .found (gfound)
   );

   // A new add can start if the result slot is empty or is being drained this cycle.
   assign can_issue = (state == EMPTY) | (rsp_valid & rsp_ready);
   assign issue     = can_issue & gfound;
   assign req_ready = (rst_n && can_issue) ? grant : '0;
   assign rsp_valid = (state == FULL);
   assign next_ptr  = (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      a_sel = '0;
      b_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gidx == IW'(i)) begin
            a_sel = req_a[i*XLEN +: XLEN];
            b_sel = req_b[i*XLEN +: XLEN];
         end
      end
   end

   sum #(.W(XLEN)) u_sum (
      .A0 (a_sel),
      .A1 (b_sel),
      .F  (sum_f)
   );

   // An issue takes priority over a plain drain because it refills the slot on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= EMPTY;
         rsp_data <= '0;
         rsp_id   <= '0;
         rr_ptr   <= '0;
         op_count <= '0;
      end else if (issue) begin
         state    <= FULL;
         rsp_data <= sum_f;
         rsp_id   <= gidx;
         rr_ptr   <= next_ptr;
         op_count <= op_count + 32'd1;
      end else if (rsp_valid && rsp_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed, table-driven bench for adder_arbiter.
// Covers grant rotation, carry drop, back-pressure, drain/refill and asynchronous reset.
module tb_adder_arbiter;
   import riscv_pkg::*;

   logic          clk;
   logic          rst_n;
   logic [3:0]    req_valid;
   logic [3:0]    req_ready;
   logic [127:0]  req_a;
   logic [127:0]  req_b;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   add_req_id_t   rsp_id;
   logic [31:0]   op_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]   rv;
      logic [127:0] a;
      logic [127:0] b;
      logic         rr;
      logic [3:0]   erdy;
      logic         evalid;
      logic [31:0]  edata;
      add_req_id_t  eid;
      logic [31:0]  ecnt;
   } vec_t;

   localparam logic [127:0] DA = {32'd40, 32'd30, 32'd20, 32'd10};
   localparam logic [127:0] DB = {32'd4, 32'd3, 32'd2, 32'd1};

   vec_t vecs[18];
   vec_t extra;

   adder_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int n, input logic [31:0] act,
                              input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s (vector %0d): got %h, expected %h", name, n, act, exp);
      end
   endtask

   // Drive on the falling edge, check the grant before the rising edge, check the result after it.
   task automatic applyStimulus(input vec_t v, input int n);
      @(negedge clk);
      req_valid = v.rv;
      req_a     = v.a;
      req_b     = v.b;
      rsp_ready = v.rr;
      #1;
      checkOutput("req_ready", n, 32'(req_ready), 32'(v.erdy));
      @(posedge clk);
      #1;
      checkOutput("rsp_valid", n, 32'(rsp_valid), 32'(v.evalid));
      checkOutput("rsp_data", n, rsp_data, v.edata);
      checkOutput("rsp_id", n, 32'(rsp_id), 32'(v.eid));
      checkOutput("op_count", n, op_count, v.ecnt);
   endtask

   initial begin
      // Single requester, then carry-drop cases
      vecs[0]  = '{4'b0001, {DA[127:32], 32'd5}, {DB[127:32], 32'd7}, 1'b1,
                   4'b0001, 1'b1, 32'd12, 2'd0, 32'd1};
      vecs[1]  = '{4'b0001, {DA[127:32], 32'h8000_0000}, {DB[127:32], 32'h8000_0000}, 1'b1,
                   4'b0001, 1'b1, 32'd0, 2'd0, 32'd2};
      vecs[2]  = '{4'b0001, {DA[127:32], 32'hFFFF_FFFF}, {DB[127:32], 32'd1}, 1'b1,
                   4'b0001, 1'b1, 32'd0, 2'd0, 32'd3};
      // All four valid: rotation from pointer 1 with wrap through 3 -> 0
      vecs[3]  = '{4'b1111, DA, DB, 1'b1, 4'b0010, 1'b1, 32'd22, 2'd1, 32'd4};
      vecs[4]  = '{4'b1111, DA, DB, 1'b1, 4'b0100, 1'b1, 32'd33, 2'd2, 32'd5};
      vecs[5]  = '{4'b1111, DA, DB, 1'b1, 4'b1000, 1'b1, 32'd44, 2'd3, 32'd6};
      vecs[6]  = '{4'b1111, DA, DB, 1'b1, 4'b0001, 1'b1, 32'd11, 2'd0, 32'd7};
      vecs[7]  = '{4'b1111, DA, DB, 1'b1, 4'b0010, 1'b1, 32'd22, 2'd1, 32'd8};
      // Back-pressure for three cycles, then release with a same-cycle grant
      vecs[8]  = '{4'b1111, DA, DB, 1'b0, 4'b0000, 1'b1, 32'd22, 2'd1, 32'd8};
      vecs[9]  = '{4'b1111, DA, DB, 1'b0, 4'b0000, 1'b1, 32'd22, 2'd1, 32'd8};
      vecs[10] = '{4'b1111, DA, DB, 1'b0, 4'b0000, 1'b1, 32'd22, 2'd1, 32'd8};
      vecs[11] = '{4'b1111, DA, DB, 1'b1, 4'b0100, 1'b1, 32'd33, 2'd2, 32'd9};
      // After grant 2, only 1 and 3 requesting
      vecs[12] = '{4'b1010, DA, DB, 1'b1, 4'b1000, 1'b1, 32'd44, 2'd3, 32'd10};
      vecs[13] = '{4'b1010, DA, DB, 1'b1, 4'b0010, 1'b1, 32'd22, 2'd1, 32'd11};
      // Drain to empty, idle, then issue from empty with consumer stalled
      vecs[14] = '{4'b0000, DA, DB, 1'b1, 4'b0000, 1'b0, 32'd22, 2'd1, 32'd11};
      vecs[15] = '{4'b0000, DA, DB, 1'b0, 4'b0000, 1'b0, 32'd22, 2'd1, 32'd11};
      vecs[16] = '{4'b0100, DA, DB, 1'b0, 4'b0100, 1'b1, 32'd33, 2'd2, 32'd12};
      vecs[17] = '{4'b0100, DA, DB, 1'b0, 4'b0000, 1'b1, 32'd33, 2'd2, 32'd12};

      rst_n     = 1'b0;
      req_valid = 4'b1111;
      req_a     = DA;
      req_b     = DB;
      rsp_ready = 1'b1;
      #3;
      checkOutput("reset req_ready", -1, 32'(req_ready), 32'd0);
      checkOutput("reset rsp_valid", -1, 32'(rsp_valid), 32'd0);
      checkOutput("reset rsp_data", -1, rsp_data, 32'd0);
      checkOutput("reset rsp_id", -1, 32'(rsp_id), 32'd0);
      checkOutput("reset op_count", -1, op_count, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("reset held op_count", -1, op_count, 32'd0);
      req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

      // Asynchronous reset between edges while FULL
      #2;
      checkOutput("pre-reset rsp_valid", 100, 32'(rsp_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("mid reset rsp_valid", 100, 32'(rsp_valid), 32'd0);
      checkOutput("mid reset rsp_data", 100, rsp_data, 32'd0);
      checkOutput("mid reset rsp_id", 100, 32'(rsp_id), 32'd0);
      checkOutput("mid reset op_count", 100, op_count, 32'd0);
      checkOutput("mid reset req_ready", 100, 32'(req_ready), 32'd0);
      req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b1;

      // Pointer back at 0: all-valid grants 0, then the first sequence repeats
      extra = '{4'b1111, DA, DB, 1'b1, 4'b0001, 1'b1, 32'd11, 2'd0, 32'd1};
      applyStimulus(extra, 101);
      extra = vecs[0];
      extra.ecnt = 32'd2;
      applyStimulus(extra, 102);
      extra = '{4'b0000, DA, DB, 1'b1, 4'b0000, 1'b0, 32'd12, 2'd0, 32'd2};
      applyStimulus(extra, 103);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
